// File: rtl/slot2_bus_master.sv
// -----------------------------------------------------------------------------
// slot2_bus_master
//
// Purpose:
//   Sequences the GBA slot-2 cartridge bus (ncs/nrd/nwr, multiplexed AD[15:0],
//   A[23:16]) for one host requester. A {addr, direction, beat count} request
//   becomes one nonsequential address phase followed by sequential strobes,
//   with wait states counted in phi cycles.
//
// Handshakes:
//   req is sampled only in IDLE. Acceptance is signalled by a 1-cycle req_ack
//   pulse and req is not looked at again until the FSM is back in IDLE, so a
//   req raised while busy simply stays pending. wdata is driven straight onto
//   AD for the whole write strobe; wdata_rd pulses on the final strobe cycle
//   and the next beat's wdata must be valid from the following cycle on.
//   rdata is held and rdata_vld pulses for one cycle per read beat. done
//   pulses once per completed burst.
//
// Ports:
//   phi, nrst            bus clock (rising edge), async active-low reset
//   req, req_wr          request valid / 1 = write burst
//   req_addr[23:0]       halfword start address
//   req_len[7:0]         beats minus one
//   req_ack              request accepted pulse
//   wdata[15:0], wdata_rd  write data / consumed pulse
//   rdata[15:0], rdata_vld read data / valid pulse
//   busy, done           burst in progress / burst complete pulse
//   ncs, nrd, nwr        active-low bus strobes
//   a_hi[7:0]            address bits [23:16]
//   ad_out, ad_oe, ad_in AD drive value, output enable, sampled value
//   dbg_state[2:0]       current FSM state
//
// Configuration:
//   SLOT2_WAITCFG_EN  adds cfg_we / cfg_nwait[2:0] / cfg_swait[1:0]; the wait
//                     counts become registers loaded from these ports while
//                     IDLE (reset to N_WAIT/S_WAIT). Undefined: fixed waits.
// -----------------------------------------------------------------------------
module slot2_bus_master #(
  parameter int N_WAIT = 3,
  parameter int S_WAIT = 1
) (
  input  logic        phi,
  input  logic        nrst,
  input  logic        req,
  input  logic        req_wr,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_len,
  output logic        req_ack,
  input  logic [15:0] wdata,
  output logic        wdata_rd,
  output logic [15:0] rdata,
  output logic        rdata_vld,
  output logic        busy,
  output logic        done,
  output logic        ncs,
  output logic        nrd,
  output logic        nwr,
  output logic [7:0]  a_hi,
  output logic [15:0] ad_out,
  output logic        ad_oe,
  input  logic [15:0] ad_in,
`ifdef SLOT2_WAITCFG_EN
  input  logic        cfg_we,
  input  logic [2:0]  cfg_nwait,
  input  logic [1:0]  cfg_swait,
`endif
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_STROBE  = 3'd2,
    S_RECOVER = 3'd3,
    S_REOPEN  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic        wr_q, wr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rdata_vld_q, rdata_vld_d;
  logic        done_q, done_d;
  logic        ack_q, ack_d;
  logic [23:0] addr_inc;
  logic [7:0]  wait_n;
  logic [7:0]  wait_s;

  // ---------------------------------------------------------------------------
  // Wait-state source
  // ---------------------------------------------------------------------------
`ifdef SLOT2_WAITCFG_EN
  logic [7:0] nwait_q, nwait_d;
  logic [7:0] swait_q, swait_d;

  always_comb begin
    nwait_d = nwait_q;
    swait_d = swait_q;
    // Loading only in IDLE keeps a burst's timing stable once it has started.
    if (state_q == S_IDLE && cfg_we) begin
      nwait_d = {5'd0, cfg_nwait};
      swait_d = {6'd0, cfg_swait};
    end
  end

  always_ff @(posedge phi or negedge nrst) begin
    if (!nrst) begin
      nwait_q <= 8'(N_WAIT);
      swait_q <= 8'(S_WAIT);
    end else begin
      nwait_q <= nwait_d;
      swait_q <= swait_d;
    end
  end

  assign wait_n = nwait_q;
  assign wait_s = swait_q;
`else
  assign wait_n = 8'(N_WAIT);
  assign wait_s = 8'(S_WAIT);
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  assign addr_inc = addr_q + 24'd1;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    rdata_vld_d = 1'b0;
    done_d      = 1'b0;
    ack_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = req_addr;
          len_d   = req_len;
          wr_d    = req_wr;
          ack_d   = 1'b1;
          state_d = S_ADDR;
        end
      end

      // Every strobe entered from ADDR is nonsequential (start of burst or
      // after a reopen), so it always gets the long wait.
      S_ADDR: begin
        cnt_d   = wait_n;
        state_d = S_STROBE;
      end

      // cnt_q counts remaining extra cycles; zero marks the final strobe cycle.
      S_STROBE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          if (!wr_q) begin
            rdata_d     = ad_in;
            rdata_vld_d = 1'b1;
          end
          if (len_q == 8'd0) begin
            // Last beat: strobe and ncs rise together on this edge.
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            // The address advance is committed on the edge into RECOVER/REOPEN
            // so that REOPEN can already present the new upper address.
            addr_d = addr_inc;
            len_d  = len_q - 8'd1;
            // The cart's internal counter only covers AD[15:0]; a carry out of
            // it (including the 24-bit wrap) needs a fresh address phase.
            state_d = (addr_inc[15:0] == 16'd0) ? S_REOPEN : S_RECOVER;
          end
        end
      end

      S_RECOVER: begin
        cnt_d   = wait_s;
        state_d = S_STROBE;
      end

      S_REOPEN: begin
        state_d = S_ADDR;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge phi or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      addr_q      <= 24'd0;
      len_q       <= 8'd0;
      wr_q        <= 1'b0;
      cnt_q       <= 8'd0;
      rdata_q     <= 16'd0;
      rdata_vld_q <= 1'b0;
      done_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      rdata_vld_q <= rdata_vld_d;
      done_q      <= done_d;
      ack_q       <= ack_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from state so the async reset releases the bus at once.
  // ---------------------------------------------------------------------------
  logic in_strobe;
  assign in_strobe = (state_q == S_STROBE);

  assign ncs      = !((state_q == S_ADDR) || in_strobe || (state_q == S_RECOVER));
  assign nrd      = !(in_strobe && !wr_q);
  assign nwr      = !(in_strobe && wr_q);
  // Enabled only in ADDR or a write strobe, so never overlaps nrd low.
  assign ad_oe    = (state_q == S_ADDR) || (in_strobe && wr_q);
  assign ad_out   = (state_q == S_ADDR)     ? addr_q[15:0] :
                    (in_strobe && wr_q)     ? wdata        : 16'd0;
  assign a_hi     = (state_q == S_IDLE) ? 8'd0 : addr_q[23:16];
  assign wdata_rd = in_strobe && wr_q && (cnt_q == 8'd0);
  assign busy     = (state_q != S_IDLE);
  assign req_ack  = ack_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign rdata_vld = rdata_vld_q;
  assign dbg_state = state_q;

endmodule
